// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply early termination).
package muldiv_pkg;

  localparam int XLEN = 32;

  // M-op select, encoded exactly as instruction funct3.
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Quotient returned for any divide by zero.
  localparam logic [XLEN-1:0] DIV0_Q     = {XLEN{1'b1}};
  // Most negative signed value; only operand that overflows signed divide.
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer signal bundle.
// Optional build macro: MULDIV_EARLY_OUT_EN (no effect on this file).
//
// Handshake: the pipeline (master) raises issue with funct3/a/b stable while
// the M-op sits in EX. The sequencer (slave) accepts in any IDLE cycle where
// issue & ~flush, then holds stall high until its DONE cycle; result_valid
// pulses for exactly that DONE cycle and result stays held afterwards. issue
// may remain high during DONE (same instruction still in EX) and is ignored.
interface muldiv_seq_if #(
  parameter int XLEN = muldiv_pkg::XLEN
);
  logic            issue;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;

  modport master (
    output issue, flush, funct3, a, b,
    input  stall, busy, result, result_valid
  );

  modport slave (
    input  issue, flush, funct3, a, b,
    output stall, busy, result, result_valid
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// One iteration of the shift-add multiplier or restoring divider.
// Optional build macro: MULDIV_EARLY_OUT_EN (no effect on this file).
//
// Multiply: {acc, op} is the partial product; op[0] is the next multiplier
// bit and opnd is the multiplicand. Divide: acc is the partial remainder,
// op shifts the dividend out at the top and the quotient in at the bottom,
// opnd is the divisor.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] op_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] op_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Next {acc, op}: add-then-shift-right for multiply, shift-left-then-trial-
  // subtract for divide. diff[XLEN] is the borrow since acc < divisor.
  always_comb begin
    sum    = {1'b0, acc_i} + (op_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    rem_sh = {acc_i, op_i[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    acc_o  = sum[XLEN:1];
    op_o   = {sum[0], op_i[XLEN-1:1]};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        op_o  = {op_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = rem_sh[XLEN-1:0];
        op_o  = {op_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer for the EX stage.
// Owns the IDLE/CALC/DONE FSM, iteration counter, sign fix-up, special
// cases, pipeline stall and result register.
// Optional build macro: MULDIV_EARLY_OUT_EN -- multiplies leave CALC once the
// remaining multiplier bits are zero and align the product in one shift.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus,
  output state_e      dbg_state_o
);

  localparam int CW = $clog2(XLEN + 1);

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] op_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] result_q;
  funct3_e         f3_q;
  logic            neg_q;
  logic            valid_q;

  funct3_e         f3_in;
  logic            in_is_div;
  logic            in_is_rem;
  logic            in_sa;
  logic            in_sb;
  logic            in_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic            accept;

  logic [XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]   op_nxt;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s;
  logic [XLEN-1:0]   r_s;
  logic [XLEN-1:0]   calc_res;
  logic              mul_early;
  logic              last_iter;
`ifdef MULDIV_EARLY_OUT_EN
  logic [CW-1:0]     shamt;
  logic [XLEN-1:0]   rem_mask;
`endif

  // Decode the op in EX: operand signedness, magnitudes, result sign and the
  // divide cases that bypass iteration. MUL is treated as signed x signed;
  // its low half is the same either way.
  always_comb begin
    f3_in     = funct3_e'(bus.funct3);
    in_is_div = bus.funct3[2];
    in_is_rem = bus.funct3[2] & bus.funct3[1];
    in_sa     = (f3_in == F3_MUL || f3_in == F3_MULH || f3_in == F3_MULHSU ||
                 f3_in == F3_DIV || f3_in == F3_REM) && bus.a[XLEN-1];
    in_sb     = (f3_in == F3_MUL || f3_in == F3_MULH ||
                 f3_in == F3_DIV || f3_in == F3_REM) && bus.b[XLEN-1];
    a_mag     = in_sa ? -bus.a : bus.a;
    b_mag     = in_sb ? -bus.b : bus.b;
    in_neg    = in_is_rem ? in_sa : (in_sa ^ in_sb);
    div_zero  = in_is_div && (bus.b == '0);
    div_ovf   = in_is_div && !bus.funct3[0] &&
                (bus.a == SIGNED_MIN) && (bus.b == DIV0_Q);
    if (div_zero) begin
      special_res = in_is_rem ? bus.a : DIV0_Q;
    end else begin
      special_res = in_is_rem ? '0 : SIGNED_MIN;
    end
    accept = (state_q == S_IDLE) && bus.issue && !bus.flush;
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .is_div_i (f3_q[2]),
    .acc_i    (acc_q),
    .op_i     (op_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_nxt),
    .op_o     (op_nxt)
  );

  // Decide whether this CALC cycle is the last one and form the signed,
  // half-selected result from the post-iteration registers.
  always_comb begin
    prod      = {acc_nxt, op_nxt};
    mul_early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    // Remaining iterations would only shift right; do them all at once.
    shamt     = count_q - CW'(1);
    rem_mask  = (XLEN'(1) << shamt) - XLEN'(1);
    mul_early = !f3_q[2] && ((op_nxt & rem_mask) == '0);
    prod      = prod >> shamt;
`endif
    last_iter = (count_q == CW'(1)) || mul_early;
    prod_s    = neg_q ? -prod : prod;
    q_s       = neg_q ? -op_nxt : op_nxt;
    r_s       = neg_q ? -acc_nxt : acc_nxt;
    if (f3_q[2]) begin
      calc_res = f3_q[1] ? r_s : q_s;
    end else if (f3_q == F3_MUL) begin
      calc_res = prod_s[XLEN-1:0];
    end else begin
      calc_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Sequencer FSM with registered result and one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      f3_q     <= F3_MUL;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            f3_q    <= f3_in;
            neg_q   <= in_neg;
            count_q <= CW'(XLEN);
            acc_q   <= '0;
            if (div_zero || div_ovf) begin
              state_q  <= S_DONE;
              result_q <= special_res;
              valid_q  <= 1'b1;
            end else begin
              state_q <= S_CALC;
              if (in_is_div) begin
                op_q   <= a_mag;
                opnd_q <= b_mag;
              end else begin
                op_q   <= b_mag;
                opnd_q <= a_mag;
              end
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q   <= acc_nxt;
            op_q    <= op_nxt;
            count_q <= count_q - CW'(1);
            if (last_iter) begin
              state_q  <= S_DONE;
              result_q <= calc_res;
              valid_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall        = accept || (state_q == S_CALC);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random M-ops
// compared against a 64-bit arithmetic reference model.
// Optional build macro: MULDIV_EARLY_OUT_EN (changes expected multiply latency).
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  state_e dbg_state;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural RV32M result from 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycles from the accepting cycle to the result_valid cycle.
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    logic [31:0] mag;
    int          k;
    if (f3[2]) begin
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    mag = ((f3 == 3'd0 || f3 == 3'd1) && b[31]) ? -b : b;
    k = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i;
`ifdef MULDIV_EARLY_OUT_EN
    return k + 2;
`else
    return (k >= 0) ? 33 : 0;
`endif
  endfunction

  // Driver: present an M-op at a negedge, hold issue until the valid pulse
  // (as the pipeline does), then let the instruction leave EX.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat, stalls, exp_lat;
    exp_q.push_back(ref_result(f3, a, b));
    exp_lat    = ref_latency(f3, a, b);
    bus.issue  = 1'b1;
    bus.flush  = 1'b0;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    #1;
    stalls = bus.stall ? 1 : 0;
    lat    = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.stall) stalls++;
    end while (!bus.result_valid && lat < 100);
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_cycles", 32'(stalls), 32'(exp_lat));
    check("busy_in_done", 32'(bus.busy), 32'd1);
    last_res = exp_q.pop_front();
    check("result", bus.result, last_res);
    @(negedge clk);
    bus.issue = 1'b0;
    #1;
    check("idle_after_done", 32'(bus.busy), 32'd0);
    check("valid_one_cycle", 32'(bus.result_valid), 32'd0);
    check("result_held", bus.result, last_res);
  endtask

  logic [2:0]  rf3;
  logic [31:0] ra, rb;
  int          seen_valid;

  initial begin
    reset      = 1'b1;
    bus.issue  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.a      = '0;
    bus.b      = '0;
    last_res   = '0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd5, 32'd100, 32'd0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd7, 32'h1234_5678, 32'd0);
    do_op(3'd0, 32'd5, 32'd3);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op(3'd0, 32'd9, 32'd0);

    // Flush mid-DIV: abort without a pulse, result keeps prior value.
    bus.issue  = 1'b1;
    bus.funct3 = 3'd4;
    bus.a      = 32'd1000;
    bus.b      = 32'd7;
    seen_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.result_valid) seen_valid++;
    end
    bus.flush = 1'b1;
    bus.issue = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_idle", 32'(bus.busy), 32'd0);
    check("flush_no_valid", 32'(bus.result_valid | (seen_valid != 0)), 32'd0);
    check("flush_result_held", bus.result, last_res);
    do_op(3'd0, 32'hFFFF_FF00, 32'd12345);

    // issue together with flush in IDLE is not accepted.
    bus.issue = 1'b1;
    bus.flush = 1'b1;
    #1;
    check("flush_issue_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.issue = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("flush_issue_idle", 32'(bus.busy), 32'd0);

    // Reset mid-CALC wins over everything.
    bus.issue  = 1'b1;
    bus.funct3 = 3'd5;
    bus.a      = 32'hDEAD_BEEF;
    bus.b      = 32'd3;
    repeat (5) @(negedge clk);
    reset     = 1'b1;
    bus.issue = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_stall", 32'(bus.stall), 32'd0);
    check("midrst_valid", 32'(bus.result_valid), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    reset    = 1'b0;
    last_res = '0;
    @(negedge clk);

    // Random M-ops with corner-biased operands
    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      do_op(rf3, ra, rb);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
